mc_ctrl: RTL
============

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle main controller for the MIPS datapath. Sequences each instruction through FETCH/DECODE/EXE/MEM/WB.
//  Drives all datapath selects and enables: EXTOp for the immediate extender, ALUOp, NPCOp and the write enables.
//  Waits on a data-memory ready handshake. Sits beside IR and reads opcode/funct from the IR output.
// PARAMETERS
//  DM_HANDSHAKE  1  1: the MEM state waits for dm_ready; 0: dm_ready is ignored and treated as 1
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  asynchronous, active-low reset
//  opcode       in   6  IR[31:26], stable from DECODE onward
//  funct        in   6  IR[5:0]
//  zero         in   1  ALU equal flag (rs==rt), valid in EXE
//  dm_ready     in   1  data memory has completed the access this cycle
//  IRWr         out  1  IR load enable
//  PCWr         out  1  PC load enable
//  NPCOp        out  2  00 PC+4, 01 branch, 10 j/jal, 11 jr
//  RFWr         out  1  register file write enable
//  DMWr         out  1  data memory write enable
//  EXTOp        out  2  `EXT_ZERO 00, `EXT_SIGN 01, `EXT_LUI 10
//  ALUOp        out  3  000 add, 001 sub, 010 or
//  ALUSrcB      out  1  0 = rt data, 1 = EXTResult
//  RegDst       out  2  00 rt, 01 rd, 10 $31
//  WDSel        out  2  00 ALU, 01 DM, 10 PC reg (already PC+4)
//  instr_done   out  1  high in the last cycle of every instruction
//  illegal      out  1  high in DECODE for an unsupported opcode/funct
// BEHAVIOUR
//  - State register (3b): FETCH 0, DECODE 1, EXE 2, MEM 3, WB 4. Reset low => FETCH, asynchronously.
//  - Outputs are combinational from the state, opcode, funct, zero and dm_ready.
//    Default for every output is 0 (EXTOp 00, NPCOp 00).
//  - While reset is low, all outputs are forced to 0, including mid-instruction. A DMWr that was high drops immediately.
//  - Supported: addu(0/21h), subu(0/23h), jr(0/08h), sll-nop(0/00h, instr==0), ori 0Dh, lui 0Fh, lw 23h, sw 2Bh, beq 04h, jal 03h.
//  - FETCH: IRWr=1, PCWr=1, NPCOp=00 -> DECODE.
//  - DECODE, by instruction class:
//    - jr: PCWr=1, NPCOp=11, instr_done -> FETCH.
//    - nop: instr_done -> FETCH.
//    - jal: -> WB.
//    - illegal: illegal=1, instr_done, no writes -> FETCH.
//    - all others: -> EXE.
//  - EXE, by instruction class:
//    - addu/subu: ALUOp add/sub, ALUSrcB=0 -> WB.
//    - ori: EXTOp=ZERO, ALUOp=or, ALUSrcB=1 -> WB.
//    - lui: EXTOp=LUI, ALUOp=add, ALUSrcB=1 -> WB.
//    - lw/sw: EXTOp=SIGN, ALUOp=add, ALUSrcB=1 -> MEM.
//    - beq: EXTOp=SIGN, ALUOp=sub, ALUSrcB=0; if zero then PCWr=1 and NPCOp=01. instr_done -> FETCH.
//  - MEM:
//    - sw: DMWr=1 every cycle until dm_ready; when dm_ready: instr_done -> FETCH.
//    - lw: stay until dm_ready, then -> WB.
//    - No timeout; the state holds indefinitely.
//  - WB: RFWr=1 for exactly one cycle, instr_done, -> FETCH.
//    - R-type: RegDst=01, WDSel=00.
//    - ori/lui: RegDst=00, WDSel=00.
//    - lw: RegDst=00, WDSel=01.
//    - jal: RegDst=10, WDSel=10, PCWr=1, NPCOp=10.
//  - CPI: nop/jr 2; beq 3; R/ori/lui/jal 4 (jal skips EXE: 3); sw 4+wait; lw 5+wait.
//  - Unreachable state encodings 5..7 -> FETCH next cycle, all outputs 0.
// STRUCTURE
//  - macro.v: opcode/funct codes, `EXT_*, ALU_*, NPC_*, RegDst/WDSel codes, S_* state codes.
//  - Sub-module mc_decode (combinational): opcode/funct -> one-hot class {rtype_add, rtype_sub, jr, nop, ori, lui, lw, sw, beq, jal, illegal}.
//  - mc_ctrl holds the state register and the output decode.
// TESTING
//  1. reset low for 3 cycles, then high, with IR=addu: IRWr/PCWr=1 in the first cycle. After 4 cycles: RFWr=1, RegDst=01, WDSel=00, instr_done=1.
//  2. ori (0x3421FFFF): EXE shows EXTOp=00, ALUOp=010, ALUSrcB=1. lui (0x3C011234): EXE shows EXTOp=10.
//  3. lw with dm_ready low for 2 cycles in MEM: stays in MEM for 3 cycles. Then WB with RFWr=1, WDSel=01. Total 7 cycles.
//     With DM_HANDSHAKE=0: 5 cycles.
//  4. beq, EXE cycle: zero=1 -> PCWr=1, NPCOp=01, EXTOp=01. zero=0 -> PCWr=0. Both cases end in FETCH after 3 cycles.
//  5. sw: assert reset low mid-MEM while DMWr=1 -> DMWr falls in the same cycle. After release, the state is FETCH.
//  6. opcode 0x3F: illegal=1 in DECODE, no RFWr/DMWr/PCWr. jal: 3 cycles, WB has RegDst=10, WDSel=10, NPCOp=10, PCWr=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller.
// Holds the opcode/funct codes, the datapath select codes, the state
// encoding and the one-hot instruction class produced by mc_decode.
package mc_ctrl_pkg;

   // opcode field IR[31:26]
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // funct field IR[5:0] for R-type
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;

   // immediate extender
   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;

   // ALU operation
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;

   // next-PC source
   localparam logic [1:0] NPC_PC4 = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_JR  = 2'b11;

   // register-file destination select
   localparam logic [1:0] RD_RT  = 2'b00;
   localparam logic [1:0] RD_RD  = 2'b01;
   localparam logic [1:0] RD_R31 = 2'b10;

   // register-file write-data select
   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_DM  = 2'b01;
   localparam logic [1:0] WD_PC  = 2'b10;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXE    = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   // exactly one bit set for any opcode/funct pair
   typedef struct packed {
      logic rtype_add;
      logic rtype_sub;
      logic jr;
      logic nop;
      logic ori;
      logic lui;
      logic lw;
      logic sw;
      logic beq;
      logic jal;
      logic illegal;
   } cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier.
// Ports:
//   opcode  in  6  IR[31:26]
//   funct   in  6  IR[5:0]
//   cls     out    one-hot instruction class (cls_t)
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output cls_t       cls
);

   always_comb begin
      cls = '0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: cls.rtype_add = 1'b1;
               FN_SUBU: cls.rtype_sub = 1'b1;
               FN_JR:   cls.jr        = 1'b1;
               // only sll is decoded from funct 0; the all-zero word acts as nop
               FN_SLL:  cls.nop       = 1'b1;
               default: cls.illegal   = 1'b1;
            endcase
         end
         OP_ORI:  cls.ori     = 1'b1;
         OP_LUI:  cls.lui     = 1'b1;
         OP_LW:   cls.lw      = 1'b1;
         OP_SW:   cls.sw      = 1'b1;
         OP_BEQ:  cls.beq     = 1'b1;
         OP_JAL:  cls.jal     = 1'b1;
         default: cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS datapath.
// Sequences each instruction through FETCH/DECODE/EXE/MEM/WB and drives
// every datapath select and write enable combinationally from the state,
// the decoded instruction class, zero and dm_ready.
// Ports:
//   clk, reset              clock (rising edge), async active-low reset
//   opcode, funct           instruction fields from the IR output
//   zero                    ALU equal flag, sampled in EXE for beq
//   dm_ready                data memory access complete (MEM state)
//   IRWr, PCWr, NPCOp       IR / PC load control
//   RFWr, RegDst, WDSel     register file write control
//   DMWr                    data memory write enable
//   EXTOp, ALUOp, ALUSrcB   extender / ALU control
//   instr_done              last cycle of every instruction
//   illegal                 unsupported instruction seen in DECODE
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int DM_HANDSHAKE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       dm_ready,
   output logic       IRWr,
   output logic       PCWr,
   output logic [1:0] NPCOp,
   output logic       RFWr,
   output logic       DMWr,
   output logic [1:0] EXTOp,
   output logic [2:0] ALUOp,
   output logic       ALUSrcB,
   output logic [1:0] RegDst,
   output logic [1:0] WDSel,
   output logic       instr_done,
   output logic       illegal
);

   state_t state_q, state_d;
   cls_t   cls;
   logic   rdy;

   mc_decode u_decode (
      .opcode (opcode),
      .funct  (funct),
      .cls    (cls)
   );

   // without the handshake every memory access completes in one MEM cycle
   assign rdy = (DM_HANDSHAKE != 0) ? dm_ready : 1'b1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = S_FETCH;
      IRWr       = 1'b0;
      PCWr       = 1'b0;
      NPCOp      = NPC_PC4;
      RFWr       = 1'b0;
      DMWr       = 1'b0;
      EXTOp      = EXT_ZERO;
      ALUOp      = ALU_ADD;
      ALUSrcB    = 1'b0;
      RegDst     = RD_RT;
      WDSel      = WD_ALU;
      instr_done = 1'b0;
      illegal    = 1'b0;

      case (state_q)
         S_FETCH: begin
            IRWr    = 1'b1;
            PCWr    = 1'b1;
            NPCOp   = NPC_PC4;
            state_d = S_DECODE;
         end

         S_DECODE: begin
            if (cls.jr) begin
               PCWr       = 1'b1;
               NPCOp      = NPC_JR;
               instr_done = 1'b1;
            end else if (cls.nop) begin
               instr_done = 1'b1;
            end else if (cls.illegal) begin
               illegal    = 1'b1;
               instr_done = 1'b1;
            end else if (cls.jal) begin
               // the PC register already holds PC+4, so jal needs no ALU work
               state_d = S_WB;
            end else begin
               state_d = S_EXE;
            end
         end

         S_EXE: begin
            state_d = S_WB;
            if (cls.rtype_add) begin
               ALUOp = ALU_ADD;
            end else if (cls.rtype_sub) begin
               ALUOp = ALU_SUB;
            end else if (cls.ori) begin
               EXTOp   = EXT_ZERO;
               ALUOp   = ALU_OR;
               ALUSrcB = 1'b1;
            end else if (cls.lui) begin
               EXTOp   = EXT_LUI;
               ALUOp   = ALU_ADD;
               ALUSrcB = 1'b1;
            end else if (cls.lw || cls.sw) begin
               EXTOp   = EXT_SIGN;
               ALUOp   = ALU_ADD;
               ALUSrcB = 1'b1;
               state_d = S_MEM;
            end else if (cls.beq) begin
               EXTOp      = EXT_SIGN;
               ALUOp      = ALU_SUB;
               instr_done = 1'b1;
               state_d    = S_FETCH;
               if (zero) begin
                  PCWr  = 1'b1;
                  NPCOp = NPC_BR;
               end
            end else begin
               state_d = S_FETCH;
            end
         end

         S_MEM: begin
            if (cls.sw) begin
               // hold the write strobe until memory acknowledges it
               DMWr = 1'b1;
               if (rdy) instr_done = 1'b1;
               else     state_d    = S_MEM;
            end else if (cls.lw) begin
               state_d = rdy ? S_WB : S_MEM;
            end else begin
               state_d = S_FETCH;
            end
         end

         S_WB: begin
            RFWr       = 1'b1;
            instr_done = 1'b1;
            if (cls.rtype_add || cls.rtype_sub) begin
               RegDst = RD_RD;
               WDSel  = WD_ALU;
            end else if (cls.lw) begin
               RegDst = RD_RT;
               WDSel  = WD_DM;
            end else if (cls.jal) begin
               RegDst = RD_R31;
               WDSel  = WD_PC;
               PCWr   = 1'b1;
               NPCOp  = NPC_J;
            end else begin
               RegDst = RD_RT;
               WDSel  = WD_ALU;
            end
         end

         default: state_d = S_FETCH;
      endcase

      // reset silences the datapath immediately, even mid-instruction
      if (!reset) begin
         IRWr       = 1'b0;
         PCWr       = 1'b0;
         NPCOp      = NPC_PC4;
         RFWr       = 1'b0;
         DMWr       = 1'b0;
         EXTOp      = EXT_ZERO;
         ALUOp      = ALU_ADD;
         ALUSrcB    = 1'b0;
         RegDst     = RD_RT;
         WDSel      = WD_ALU;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end
   end

endmodule
